branch_history_predictor: RTL
=============================

// Module: branch_history_predictor
// PURPOSE
//   Branch predictor ahead of the PC register in the 5-stage pipeline.
//   - Looks up fetch PC (PC register output) in a table of 2-bit saturating counters.
//   - Outputs a registered taken/not-taken prediction, aligned with the IF/ID stage.
//   - Next-PC mux uses it to choose PC+4 or the branch target for the PC register input.
//   - ID-stage branch resolution trains the table and keeps branch/mispredict statistics.
// PARAMETERS
//   BHT_ENTRIES  64     number of counters; power of two, >= 2
//   IDX_W        6      log2(BHT_ENTRIES); index = pc_i[IDX_W+1:2]
//   INIT_STATE   2'b01  counter value after reset (weakly not-taken)
//   CNT_W        16     width of statistics counters
// PORTS
//   clk_i           in   1      clock, rising edge
//   rst_i           in   1      reset, synchronous, active-high
//   start_i         in   1      core run enable; 0 = no lookup, no update
//   stall_i         in   1      fetch stall (PC write disabled); hold prediction
//   flush_i         in   1      IF/ID flush; squash registered prediction
//   pc_i            in   32     current fetch PC
//   pred_valid_o    out  1      pred_taken_o belongs to the instruction now in IF/ID
//   pred_taken_o    out  1      predicted direction (1 = taken)
//   upd_valid_i     in   1      resolved branch present this cycle
//   upd_pc_i        in   32     PC of resolved branch
//   upd_taken_i     in   1      actual outcome
//   upd_mispred_i   in   1      prediction for this branch was wrong
//   branch_cnt_o    out  CNT_W  resolved branches since reset
//   mispred_cnt_o   out  CNT_W  mispredicts since reset
// BEHAVIOUR
//   Reset (sync, rst_i=1 at posedge; overrides every other input, even mid-operation):
//     - every counter <= INIT_STATE
//     - pred_valid_o = 0, pred_taken_o = 0
//     - branch_cnt_o = 0, mispred_cnt_o = 0
//   Lookup, 1-cycle latency. Priority per posedge: rst_i > flush_i > stall_i > start_i:
//     - flush_i=1                -> pred_valid_o <= 0, pred_taken_o <= 0
//     - stall_i=1                -> both outputs hold
//     - start_i=1                -> pred_valid_o <= 1, pred_taken_o <= cnt[pc_i[IDX_W+1:2]][1]
//     - start_i=0                -> pred_valid_o <= 0, pred_taken_o <= 0
//   Update (upd_valid_i & start_i), c = cnt[upd_pc_i[IDX_W+1:2]]:
//     - upd_taken_i=1 -> c <= (c==2'b11) ? 2'b11 : c+1
//     - upd_taken_i=0 -> c <= (c==2'b00) ? 2'b00 : c-1
//     - update is not blocked by stall_i or flush_i
//   Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
//     - prediction = MSB of the counter
//   Statistics (upd_valid_i & start_i):
//     - branch_cnt_o += 1
//     - mispred_cnt_o += 1 only if upd_mispred_i=1
//     - both saturate at all-ones; no wrap
//   Aliasing: PCs with equal index bits share a counter.
//     - no tags; pc_i[1:0] and upper bits ignored
//   Same-cycle lookup and update to the same index: see CONFIGURATION.
//     - updates to a different index never affect that cycle's lookup
// CONFIGURATION
//   BHT_BYPASS_EN defined:
//     - same-cycle, same-index lookup returns the MSB of the updated (post-saturation) value
//   BHT_BYPASS_EN undefined:
//     - lookup returns the pre-update value
//     - the update becomes visible to lookups on the next cycle
// TESTING
//   1 Reset: rst_i=1 for 1 cycle, then lookup of any pc_i
//       -> pred_valid_o=1, pred_taken_o=0; both stat counters = 0.
//   2 Training: 2 updates, upd_pc_i=0x40, taken=1
//       -> lookup of pc_i=0x40 gives taken=1.
//     Then 4 more taken updates (saturated 11), then 2 not-taken
//       -> lookup gives 0 (11->10->01).
//   3 Aliasing: train 0x40 to 11, then look up 0x40+4*BHT_ENTRIES (0x140)
//       -> taken=1; pc_i=0x44 -> taken=0.
//   4 Stall/flush: prediction 1 registered, stall_i=1 for 3 cycles with pc_i changing
//       -> pred_taken_o stays 1.
//     flush_i=1 and stall_i=1 together
//       -> pred_valid_o=0, pred_taken_o=0 next cycle.
//   5 Bypass: counter 01; same cycle lookup pc_i=0x80 and taken update upd_pc_i=0x80
//       -> pred_taken_o=1 with BHT_BYPASS_EN, 0 without; next lookup gives 1 in both builds.
//   6 Stats: CNT_W=4, 20 updates, first 7 with upd_mispred_i=1
//       -> branch_cnt_o=15 (saturated), mispred_cnt_o=7.
//     start_i=0 with upd_valid_i=1
//       -> no counter or stat change.

Source files
------------

// File: rtl/branch_history_predictor.sv
// branch_history_predictor: 2-bit saturating-counter direction predictor for the fetch stage
//
// Produces a registered taken/not-taken prediction for the fetch PC that lines up
// with the IF/ID stage. ID-stage branch resolution trains the counter table and
// updates saturating branch and mispredict statistics.
//
// Ports:
//   clk_i, rst_i              clock (rising edge), synchronous active-high reset
//   start_i                   run enable; gates both lookup and update
//   stall_i                   fetch stall; registered prediction holds
//   flush_i                   IF/ID flush; registered prediction is squashed
//   pc_i                      fetch PC looked up this cycle
//   pred_valid_o/pred_taken_o registered prediction for the instruction in IF/ID
//   upd_valid_i, upd_pc_i,
//   upd_taken_i, upd_mispred_i resolved-branch training interface
//   branch_cnt_o/mispred_cnt_o saturating statistics
//
// Build option: define BHT_BYPASS_EN to forward a same-cycle, same-index update
// into the lookup; otherwise the lookup sees the pre-update counter.
module branch_history_predictor #(
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned IDX_W       = 6,
    parameter logic [1:0]  INIT_STATE  = 2'b01,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [31:0]      pc_i,
    output logic             pred_valid_o,
    output logic             pred_taken_o,
    input  logic             upd_valid_i,
    input  logic [31:0]      upd_pc_i,
    input  logic             upd_taken_i,
    input  logic             upd_mispred_i,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [1:0]       cnt_q [BHT_ENTRIES];
    logic             pred_valid_q, pred_valid_d;
    logic             pred_taken_q, pred_taken_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [1:0]       upd_cur, upd_val, lk_cnt;
    logic             upd_en;
    logic             unused_pc_bits;

    // Index bits only: byte offset and high PC bits deliberately alias.
    assign unused_pc_bits = ^{pc_i[31:IDX_W+2], pc_i[1:0], upd_pc_i[31:IDX_W+2], upd_pc_i[1:0]};

    always_comb begin
        upd_en  = upd_valid_i & start_i;
        lk_idx  = pc_i[IDX_W+1:2];
        upd_idx = upd_pc_i[IDX_W+1:2];
        upd_cur = cnt_q[upd_idx];
        upd_val = upd_taken_i ? ((upd_cur == 2'b11) ? 2'b11 : upd_cur + 2'd1)
                              : ((upd_cur == 2'b00) ? 2'b00 : upd_cur - 2'd1);
`ifdef BHT_BYPASS_EN
        lk_cnt  = (upd_en && upd_idx == lk_idx) ? upd_val : cnt_q[lk_idx];
`else
        lk_cnt  = cnt_q[lk_idx];
`endif
        // Priority: flush squashes, stall holds, otherwise start gates the lookup.
        pred_valid_d  = flush_i ? 1'b0 : stall_i ? pred_valid_q : start_i;
        pred_taken_d  = flush_i ? 1'b0 : stall_i ? pred_taken_q : (start_i & lk_cnt[1]);
        branch_cnt_d  = (upd_en && !(&branch_cnt_q)) ? branch_cnt_q + ONE : branch_cnt_q;
        mispred_cnt_d = (upd_en && upd_mispred_i && !(&mispred_cnt_q)) ? mispred_cnt_q + ONE : mispred_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) cnt_q[i] <= INIT_STATE;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (upd_en) cnt_q[upd_idx] <= upd_val;
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign pred_valid_o  = pred_valid_q;
    assign pred_taken_o  = pred_taken_q;
    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;
endmodule
